// File: rtl/tim_sched.sv
// rtl/tim_sched.sv - round-robin scheduler sharing one interval counter among NREQ requesters
// Optional macro TIM_SCHED_ABORT_EN: dropping req during COUNT abandons the interval with no done.
module tim_sched #(
  parameter int NREQ = 4,
  parameter int N    = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] load_flat,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [IDW-1:0]    cur_id
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t          state, state_n;
  logic [N-1:0]    count, count_n;
  logic [N-1:0]    ld, ld_n;
  logic [IDW-1:0]  ptr, ptr_n, cur_n, win;
  logic            found;
  logic [N-1:0]    loads [NREQ];
  logic [NREQ-1:0] owner;

  function automatic logic [IDW-1:0] inc_id(input logic [IDW-1:0] id);
    return (id == IDW'(NREQ - 1)) ? '0 : id + IDW'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      loads[i] = load_flat[i*N +: N];
    end
  end

  // Walk upward from the pointer with wrap; the first set request wins.
  always_comb begin
    logic [IDW-1:0] idx;
    win   = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
      idx = inc_id(idx);
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    ld_n    = ld;
    cur_n   = cur_id;
    ptr_n   = ptr;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = COUNT;
          ld_n    = loads[win];
          cur_n   = win;
          count_n = '0;
        end
      end
      COUNT: begin
        count_n = count + N'(1);
        // A load of zero wraps to 2^N because the compare is modulo 2^N.
        if (count == ld - N'(1)) begin
          state_n = DONE;
          count_n = '0;
        end
`ifdef TIM_SCHED_ABORT_EN
        if (!req[cur_id]) begin
          state_n = IDLE;
          count_n = '0;
          ptr_n   = inc_id(cur_id);
        end
`else
`endif
      end
      DONE: begin
        state_n = IDLE;
        ptr_n   = inc_id(cur_id);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      ld     <= '0;
      cur_id <= '0;
      ptr    <= '0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      ld     <= ld_n;
      cur_id <= cur_n;
      ptr    <= ptr_n;
    end
  end

  assign owner = NREQ'(1) << cur_id;
  assign busy  = (state != IDLE);
  assign gnt   = busy ? owner : '0;
  assign done  = (state == DONE) ? owner : '0;

endmodule
